number_grid_controller: RTL and testbench
=========================================

Name: number_grid_controller

Overview:
- Sequences the 12-cell on-screen number grid: assigns each cell a pseudo-random digit, tracks which cells are live, and retires cells the player collides with.
- Respawns retired cells after a frame-counted delay and ends the round after a set number of hits.
- Sits between the collision logic and the grid display instances.
- Drives per-cell digit and enable to the display instances, and per-hit score pulses to the score block.

Parameters:
- NUM_CELLS, 12, number of grid cells (index 0..NUM_CELLS-1)
- RESPAWN_FRAMES, 60, frames a retired cell stays dark before respawn (1..255)
- HITS_PER_ROUND, 20, accepted hits that end a round (1..255)
- LFSR_SEED, 8'hA5, LFSR reset value (must be nonzero)

Ports:
- clk  in  1  system clock
- resetN  in  1  synchronous reset, active-high (sampled on rising clk)
- startOfFrame  in  1  one-cycle pulse per VGA frame
- newRound  in  1  one-cycle pulse: start/restart a round
- cellHit  in  NUM_CELLS  per-cell collision (cell DR AND player DR), level
- cellValue  out  NUM_CELLS x 4  digit shown per cell, 0..9
- cellEnable  out  NUM_CELLS  cell live/visible
- scoreValid  out  1  one-cycle pulse per accepted hit
- scoreAdd  out  4  digit of the hit cell, valid with scoreValid
- hitCount  out  8  accepted hits this round
- roundDone  out  1  high while in DONE

Behaviour:
- Reset: state=IDLE; cellValue all 0; cellEnable all 0; scoreValid=0; scoreAdd=0; hitCount=0; roundDone=0; LFSR=LFSR_SEED; all respawn counters 0; all pending flags 0. Reset overrides every other input.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every clk except during reset.
- Digit map: d=lfsr[3:0]; value = (d>9) ? d-6 : d, giving range 0..9.
- IDLE: outputs static. newRound -> FILL.
- FILL: internal index f counts 0..NUM_CELLS-1, one cell per cycle.
  - cellValue[f] <= digit, cellEnable[f] <= 1; cell i is live exactly i+1 edges after FILL entry.
  - After the last cell -> ACTIVE.
  - hitCount cleared on FILL entry; cellHit ignored during FILL.
- ACTIVE, hit accept:
  - Winner k = lowest index with cellHit[k] and cellEnable[k]; at most one hit accepted per cycle.
  - Next edge: cellEnable[k] <= 0; scoreValid <= 1 for one cycle; scoreAdd <= cellValue[k]; hitCount += 1; respawn counter[k] <= RESPAWN_FRAMES.
  - Other simultaneous hits are not lost: their cells remain enabled and are accepted in later cycles while cellHit stays high.
  - Hits on disabled cells are ignored.
- ACTIVE, respawn:
  - On each startOfFrame, every nonzero counter decrements.
  - A counter reaching 0 from 1 sets pending[k].
  - Pending cells are serviced one per cycle, lowest index first: cellValue[k] <= digit, cellEnable[k] <= 1, pending[k] <= 0.
  - If a hit accept and a respawn service land on the same cycle, both happen (necessarily different cells).
- Round end: when an accepted hit makes hitCount == HITS_PER_ROUND, next state = DONE on the same edge.
- DONE: all cellEnable <= 0; counters and pending cleared; roundDone=1; cellValue holds; hitCount holds.
- newRound in any state (FILL, ACTIVE, DONE) -> FILL on the next edge. Counters and pending are cleared, roundDone <= 0, and newRound has priority over hits and respawns.
- hitCount never wraps: max is HITS_PER_ROUND.

Test Plan:
- Reset then newRound:
  - cellEnable[i] rises i+1 cycles after newRound; all 12 high after 12 cycles.
  - All cellValue in 0..9; the 12 values match a reference LFSR model seeded 8'hA5.
- Single hit, ACTIVE, cellHit[5] pulsed for 1 cycle:
  - next edge: cellEnable[5]=0, scoreValid=1 for exactly 1 cycle, scoreAdd=prior cellValue[5], hitCount=1.
- cellHit[2], cellHit[7], cellHit[9] held together:
  - cells accepted on consecutive cycles in order 2, 7, 9; three scoreValid pulses; hitCount=3.
- Respawn with RESPAWN_FRAMES=3, hit cell 4 and cell 1 in the same frame:
  - both re-enable after the 3rd subsequent startOfFrame, cell 1 one cycle before cell 4, each with a fresh digit.
- HITS_PER_ROUND=2, two hits:
  - on the 2nd accept edge, state goes to DONE; next cycle all enables 0 and roundDone=1; further cellHit produces no scoreValid.
- Mid-ACTIVE newRound, then resetN asserted during FILL:
  - newRound restarts FILL with hitCount=0.
  - resetN returns all outputs to reset values at the next edge; the LFSR sequence restarts from 8'hA5.

Source files
------------

// File: rtl/number_grid_if.sv
// number_grid_if
//   Bundles the grid controller's frame/round/collision inputs and its
//   per-cell display and score outputs.
//   Signals:
//     startOfFrame  one-cycle pulse per video frame
//     newRound      one-cycle pulse, start or restart a round
//     cellHit       per-cell collision level
//     cellValue     per-cell digit 0..9 (NUM_CELLS x 4, packed)
//     cellEnable    per-cell live/visible
//     scoreValid    one-cycle pulse per accepted hit
//     scoreAdd      digit of the accepted cell, valid with scoreValid
//     hitCount      accepted hits in this round
//     roundDone     high while the round is over
//   master: drives the inputs (collision logic / frame timing side).
//   slave : the controller.
interface number_grid_if #(
  parameter int NUM_CELLS = 12
);
  logic                      startOfFrame;
  logic                      newRound;
  logic [NUM_CELLS-1:0]      cellHit;
  logic [NUM_CELLS-1:0][3:0] cellValue;
  logic [NUM_CELLS-1:0]      cellEnable;
  logic                      scoreValid;
  logic [3:0]                scoreAdd;
  logic [7:0]                hitCount;
  logic                      roundDone;

  modport master (
    output startOfFrame, newRound, cellHit,
    input  cellValue, cellEnable, scoreValid, scoreAdd, hitCount, roundDone
  );

  modport slave (
    input  startOfFrame, newRound, cellHit,
    output cellValue, cellEnable, scoreValid, scoreAdd, hitCount, roundDone
  );
endinterface

// File: rtl/number_grid_controller.sv
// number_grid_controller
//   Sequences the on-screen number grid: fills every cell with a
//   pseudo-random digit at round start, retires cells the player hits
//   (one per cycle, lowest index first), scores each accepted hit,
//   respawns retired cells after RESPAWN_FRAMES frames and ends the round
//   after HITS_PER_ROUND accepted hits.
//   Ports:
//     clk     system clock
//     resetN  synchronous reset, active-high
//     grid    number_grid_if slave modport (frame/round/hit inputs,
//             per-cell digit/enable and score outputs)
module number_grid_controller #(
  parameter int         NUM_CELLS      = 12,
  parameter int         RESPAWN_FRAMES = 60,
  parameter int         HITS_PER_ROUND = 20,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic         clk,
  input  logic         resetN,
  number_grid_if.slave grid
);

  localparam int IDX_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    ACTIVE,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [7:0]                lfsr_q;
  logic [IDX_W-1:0]          fill_idx_q;
  logic [NUM_CELLS-1:0][3:0] value_q;
  logic [NUM_CELLS-1:0]      enable_q;
  logic                      score_valid_q;
  logic [3:0]                score_add_q;
  logic [7:0]                hit_count_q;
  logic                      round_done_q;
  logic [NUM_CELLS-1:0]      pending_q;
  logic [7:0]                resp_cnt_q [NUM_CELLS];

  logic [NUM_CELLS-1:0]      hit_vec;
  logic [IDX_W-1:0]          hit_idx;
  logic [IDX_W-1:0]          pend_idx;
  logic                      accept;
  logic                      service;
  logic [3:0]                new_digit;

  // Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Folds a 4-bit value into 0..9 (10..15 map onto 4..9).
  function automatic logic [3:0] to_digit(input logic [3:0] d);
    return (d > 4'd9) ? d - 4'd6 : d;
  endfunction

  // The round ends at HITS_PER_ROUND, so the count must never pass it.
  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c >= 8'(HITS_PER_ROUND)) ? c : c + 8'd1;
  endfunction

  assign new_digit = to_digit(lfsr_q[3:0]);
  assign hit_vec   = grid.cellHit & enable_q;

  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    service  = 1'b0;
    hit_idx  = '0;
    pend_idx = '0;

    // Downward scan so the lowest set index is the one left standing.
    for (int i = NUM_CELLS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_idx = IDX_W'(i);
      end
      if (pending_q[i]) begin
        pend_idx = IDX_W'(i);
      end
    end

    case (state_q)
      IDLE: begin
        if (grid.newRound) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (grid.newRound) begin
          state_d = FILL;
        end else if (fill_idx_q == IDX_W'(NUM_CELLS - 1)) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (grid.newRound) begin
          state_d = FILL;
        end else begin
          accept  = |hit_vec;
          service = |pending_q;
          if (accept && (sat_inc(hit_count_q) == 8'(HITS_PER_ROUND))) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (grid.newRound) begin
          state_d = FILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      lfsr_q        <= LFSR_SEED;
      fill_idx_q    <= '0;
      value_q       <= '0;
      enable_q      <= '0;
      score_valid_q <= 1'b0;
      score_add_q   <= '0;
      hit_count_q   <= '0;
      round_done_q  <= 1'b0;
      pending_q     <= '0;
      for (int k = 0; k < NUM_CELLS; k++) begin
        resp_cnt_q[k] <= '0;
      end
    end else begin
      lfsr_q        <= lfsr_step(lfsr_q);
      score_valid_q <= 1'b0;
      if (grid.newRound) begin
        // Round (re)start beats any hit or respawn in flight.
        fill_idx_q   <= '0;
        enable_q     <= '0;
        hit_count_q  <= '0;
        round_done_q <= 1'b0;
        pending_q    <= '0;
        for (int k = 0; k < NUM_CELLS; k++) begin
          resp_cnt_q[k] <= '0;
        end
      end else begin
        case (state_q)
          FILL: begin
            value_q[fill_idx_q]  <= new_digit;
            enable_q[fill_idx_q] <= 1'b1;
            fill_idx_q           <= fill_idx_q + IDX_W'(1);
          end
          ACTIVE: begin
            if (grid.startOfFrame) begin
              for (int k = 0; k < NUM_CELLS; k++) begin
                if (resp_cnt_q[k] != 8'd0) begin
                  resp_cnt_q[k] <= resp_cnt_q[k] - 8'd1;
                  if (resp_cnt_q[k] == 8'd1) begin
                    pending_q[k] <= 1'b1;
                  end
                end
              end
            end
            // A pending cell is dark, so it can never also be the hit winner.
            if (service) begin
              value_q[pend_idx]   <= new_digit;
              enable_q[pend_idx]  <= 1'b1;
              pending_q[pend_idx] <= 1'b0;
            end
            if (accept) begin
              enable_q[hit_idx]   <= 1'b0;
              score_valid_q       <= 1'b1;
              score_add_q         <= value_q[hit_idx];
              hit_count_q         <= sat_inc(hit_count_q);
              resp_cnt_q[hit_idx] <= 8'(RESPAWN_FRAMES);
            end
          end
          DONE: begin
            enable_q     <= '0;
            pending_q    <= '0;
            round_done_q <= 1'b1;
            for (int k = 0; k < NUM_CELLS; k++) begin
              resp_cnt_q[k] <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign grid.cellValue  = value_q;
  assign grid.cellEnable = enable_q;
  assign grid.scoreValid = score_valid_q;
  assign grid.scoreAdd   = score_add_q;
  assign grid.hitCount   = hit_count_q;
  assign grid.roundDone  = round_done_q;

endmodule

// File: tb/tb_number_grid_controller.sv
// tb_number_grid_controller
//   Directed bench for number_grid_controller. dut_a (RESPAWN_FRAMES=3,
//   HITS_PER_ROUND=20) covers fill, hit arbitration, respawn, mid-round
//   restart and reset during fill; dut_b (HITS_PER_ROUND=2) covers round end.
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge after the rising edge under test.
module tb_number_grid_controller;

  logic clk;
  logic resetN;

  number_grid_if #(.NUM_CELLS(12)) ifa ();
  number_grid_if #(.NUM_CELLS(12)) ifb ();

  number_grid_controller #(
    .NUM_CELLS(12), .RESPAWN_FRAMES(3), .HITS_PER_ROUND(20), .LFSR_SEED(8'hA5)
  ) dut_a (
    .clk(clk), .resetN(resetN), .grid(ifa)
  );

  number_grid_controller #(
    .NUM_CELLS(12), .RESPAWN_FRAMES(3), .HITS_PER_ROUND(2), .LFSR_SEED(8'hA5)
  ) dut_b (
    .clk(clk), .resetN(resetN), .grid(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference LFSR; ref_prev is the state the DUT consumed at the last edge.
  logic [7:0] ref_lfsr;
  logic [7:0] ref_prev;

  function automatic logic [7:0] ref_step(input logic [7:0] s);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb};
  endfunction

  function automatic logic [3:0] ref_digit(input logic [7:0] s);
    logic [3:0] d;
    d = s[3:0];
    if (d > 4'd9) d = d - 4'd6;
    return d;
  endfunction

  always @(posedge clk) begin
    if (resetN) ref_lfsr <= 8'hA5;
    else        ref_lfsr <= ref_step(ref_lfsr);
    ref_prev <= ref_lfsr;
  end

  logic [3:0] exp_a [12];
  logic [3:0] exp_b [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at the falling edge right after the newRound edge.
  task automatic fill_check(input int sel);
    logic [11:0] en;
    logic [3:0]  v;
    logic [3:0]  want;
    logic [11:0] want_en;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      en      = sel ? ifb.cellEnable : ifa.cellEnable;
      v       = sel ? ifb.cellValue[i] : ifa.cellValue[i];
      want    = ref_digit(ref_prev);
      want_en = 12'((13'h1 << (i + 1)) - 13'h1);
      check("fill_enable", 64'(en), 64'(want_en));
      check("fill_value", 64'(v), 64'(want));
      check("fill_range", 64'(v <= 4'd9), 64'(1'b1));
      if (sel != 0) exp_b[i] = want;
      else          exp_a[i] = want;
    end
  endtask

  typedef struct {
    logic [11:0] hit;
    logic        sv;
    int          add_idx;
    logic [11:0] en;
    logic [7:0]  hc;
  } vec_t;

  vec_t vt [6];

  initial begin
    vt[0] = '{hit: 12'h020, sv: 1'b1, add_idx: 5, en: 12'hFDF, hc: 8'd1};
    vt[1] = '{hit: 12'h000, sv: 1'b0, add_idx: 0, en: 12'hFDF, hc: 8'd1};
    vt[2] = '{hit: 12'h284, sv: 1'b1, add_idx: 2, en: 12'hFDB, hc: 8'd2};
    vt[3] = '{hit: 12'h284, sv: 1'b1, add_idx: 7, en: 12'hF5B, hc: 8'd3};
    vt[4] = '{hit: 12'h284, sv: 1'b1, add_idx: 9, en: 12'hD5B, hc: 8'd4};
    vt[5] = '{hit: 12'h284, sv: 1'b0, add_idx: 0, en: 12'hD5B, hc: 8'd4};

    resetN = 1'b1;
    ifa.startOfFrame = 1'b0; ifa.newRound = 1'b0; ifa.cellHit = '0;
    ifb.startOfFrame = 1'b0; ifb.newRound = 1'b0; ifb.cellHit = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_value", 64'(ifa.cellValue), 64'd0);
    check("rst_enable", 64'(ifa.cellEnable), 64'd0);
    check("rst_score_valid", 64'(ifa.scoreValid), 64'd0);
    check("rst_score_add", 64'(ifa.scoreAdd), 64'd0);
    check("rst_hit_count", 64'(ifa.hitCount), 64'd0);
    check("rst_round_done", 64'(ifa.roundDone), 64'd0);
    resetN = 1'b0;

    // Round start and fill
    @(negedge clk);
    ifa.newRound = 1'b1;
    @(negedge clk);
    ifa.newRound = 1'b0;
    check("fill_entry_enable", 64'(ifa.cellEnable), 64'd0);
    fill_check(0);

    // Hit arbitration table
    for (int t = 0; t < 6; t++) begin
      ifa.cellHit = vt[t].hit;
      @(negedge clk);
      check("tbl_score_valid", 64'(ifa.scoreValid), 64'(vt[t].sv));
      if (vt[t].sv) check("tbl_score_add", 64'(ifa.scoreAdd), 64'(exp_a[vt[t].add_idx]));
      check("tbl_enable", 64'(ifa.cellEnable), 64'(vt[t].en));
      check("tbl_hit_count", 64'(ifa.hitCount), 64'(vt[t].hc));
    end
    ifa.cellHit = '0;

    // Mid-ACTIVE restart clears the score and refills
    ifa.newRound = 1'b1;
    @(negedge clk);
    ifa.newRound = 1'b0;
    check("restart_hit_count", 64'(ifa.hitCount), 64'd0);
    check("restart_enable", 64'(ifa.cellEnable), 64'd0);
    check("restart_score_valid", 64'(ifa.scoreValid), 64'd0);
    fill_check(0);

    // Respawn: cells 1 and 4 retired in the same frame
    ifa.cellHit = 12'h012;
    @(negedge clk);
    check("rsp_hit1_valid", 64'(ifa.scoreValid), 64'd1);
    check("rsp_hit1_add", 64'(ifa.scoreAdd), 64'(exp_a[1]));
    check("rsp_hit1_enable", 64'(ifa.cellEnable), 64'hFFD);
    @(negedge clk);
    check("rsp_hit4_valid", 64'(ifa.scoreValid), 64'd1);
    check("rsp_hit4_add", 64'(ifa.scoreAdd), 64'(exp_a[4]));
    check("rsp_hit4_enable", 64'(ifa.cellEnable), 64'hFED);
    check("rsp_hit_count", 64'(ifa.hitCount), 64'd2);
    ifa.cellHit = '0;
    for (int s = 0; s < 2; s++) begin
      ifa.startOfFrame = 1'b1;
      @(negedge clk);
      ifa.startOfFrame = 1'b0;
      check("rsp_wait_sof", 64'(ifa.cellEnable), 64'hFED);
      @(negedge clk);
      check("rsp_wait_idle", 64'(ifa.cellEnable), 64'hFED);
    end
    ifa.startOfFrame = 1'b1;
    @(negedge clk);
    ifa.startOfFrame = 1'b0;
    check("rsp_third_sof", 64'(ifa.cellEnable), 64'hFED);
    @(negedge clk);
    check("rsp_cell1_enable", 64'(ifa.cellEnable), 64'hFEF);
    check("rsp_cell1_value", 64'(ifa.cellValue[1]), 64'(ref_digit(ref_prev)));
    check("rsp_no_score", 64'(ifa.scoreValid), 64'd0);
    @(negedge clk);
    check("rsp_cell4_enable", 64'(ifa.cellEnable), 64'hFFF);
    check("rsp_cell4_value", 64'(ifa.cellValue[4]), 64'(ref_digit(ref_prev)));

    // Reset in the middle of FILL
    ifa.newRound = 1'b1;
    @(negedge clk);
    ifa.newRound = 1'b0;
    repeat (4) @(negedge clk);
    check("midfill_enable", 64'(ifa.cellEnable), 64'h00F);
    resetN = 1'b1;
    @(negedge clk);
    check("rst2_value", 64'(ifa.cellValue), 64'd0);
    check("rst2_enable", 64'(ifa.cellEnable), 64'd0);
    check("rst2_score_valid", 64'(ifa.scoreValid), 64'd0);
    check("rst2_score_add", 64'(ifa.scoreAdd), 64'd0);
    check("rst2_hit_count", 64'(ifa.hitCount), 64'd0);
    check("rst2_round_done", 64'(ifa.roundDone), 64'd0);
    // Release reset and start a round on the very next edge: LFSR goes
    // A5 -> 4A, so the cells get digits of 4A, 95, 2A = 4, 5, 4.
    resetN = 1'b0;
    ifa.newRound = 1'b1;
    @(negedge clk);
    ifa.newRound = 1'b0;
    fill_check(0);
    check("seed_cell0", 64'(ifa.cellValue[0]), 64'd4);
    check("seed_cell1", 64'(ifa.cellValue[1]), 64'd5);
    check("seed_cell2", 64'(ifa.cellValue[2]), 64'd4);

    // Round end on dut_b (two hits per round)
    ifb.newRound = 1'b1;
    @(negedge clk);
    ifb.newRound = 1'b0;
    fill_check(1);
    ifb.cellHit = 12'h001;
    @(negedge clk);
    check("done_hit1_valid", 64'(ifb.scoreValid), 64'd1);
    check("done_hit1_add", 64'(ifb.scoreAdd), 64'(exp_b[0]));
    check("done_hit1_count", 64'(ifb.hitCount), 64'd1);
    ifb.cellHit = 12'h008;
    @(negedge clk);
    check("done_hit2_valid", 64'(ifb.scoreValid), 64'd1);
    check("done_hit2_add", 64'(ifb.scoreAdd), 64'(exp_b[3]));
    check("done_hit2_count", 64'(ifb.hitCount), 64'd2);
    check("done_hit2_enable", 64'(ifb.cellEnable), 64'hFF6);
    check("done_hit2_round_done", 64'(ifb.roundDone), 64'd0);
    ifb.cellHit = 12'hFFF;
    @(negedge clk);
    check("done_enable", 64'(ifb.cellEnable), 64'd0);
    check("done_round_done", 64'(ifb.roundDone), 64'd1);
    check("done_no_score", 64'(ifb.scoreValid), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("done_hold_score", 64'(ifb.scoreValid), 64'd0);
      check("done_hold_count", 64'(ifb.hitCount), 64'd2);
      check("done_hold_flag", 64'(ifb.roundDone), 64'd1);
    end
    ifb.cellHit = '0;
    ifb.newRound = 1'b1;
    @(negedge clk);
    ifb.newRound = 1'b0;
    check("done_restart_flag", 64'(ifb.roundDone), 64'd0);
    check("done_restart_count", 64'(ifb.hitCount), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
